// File: rtl/mips32_shift_arb_pkg.sv
// Shared definitions for the two-requester shift arbiter: shift op encodings
// and the default response FIFO depth.
package mips32_shift_arb_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

  localparam int unsigned DEPTH_DEFAULT = 2;

endpackage

// File: rtl/mips32_shift.sv
// Combinational MIPS32 shifter: SLL, SRL, SRA and ROTR by a 5-bit amount.
module mips32_shift
  import mips32_shift_arb_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  input  shift_op_e   op_i,
  output logic [31:0] result_o
);

  logic [63:0] rot_wide;

  always_comb begin
    // Rotating a doubled word keeps amt=0 well defined (no 32-bit shift).
    rot_wide = {data_i, data_i} >> amt_i;
    unique case (op_i)
      OP_SLL:  result_o = data_i << amt_i;
      OP_SRL:  result_o = data_i >> amt_i;
      OP_SRA:  result_o = $unsigned($signed(data_i) >>> amt_i);
      OP_ROTR: result_o = rot_wide[31:0];
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mips32_shift_arb.sv
// Two-requester arbiter feeding one shared shifter; results and requester ids
// are queued in an in-order response FIFO. Tracks stalled request cycles.
module mips32_shift_arb
  import mips32_shift_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_data,
  input  logic [1:0][4:0]  req_amt,
  input  logic [1:0][1:0]  req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [7:0]       busy_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            ptr_q;
  logic [7:0]      busy_q;

  logic            gnt_idx;
  logic            any_valid;
  logic            pop;
  logic            push;
  logic            space;
  logic [31:0]     shift_res;

  always_comb begin
    any_valid = |req_valid;
    unique case (req_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr_q;
      default: gnt_idx = 1'b0;
    endcase
    pop   = rsp_valid & rsp_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    space = (cnt_q != DEPTH_L) || pop;
    req_ready = '0;
    if (rst_n && any_valid && space) req_ready[gnt_idx] = 1'b1;
    push = |req_ready;
  end

  mips32_shift u_shift (
    .data_i   (req_data[gnt_idx]),
    .amt_i    (req_amt[gnt_idx]),
    .op_i     (shift_op_e'(req_op[gnt_idx])),
    .result_o (shift_res)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{id: gnt_idx, data: shift_res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        ptr_q    <= ~gnt_idx;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (any_valid && !push && busy_q != '1) busy_q <= busy_q + 1'b1;
    end
  end

  assign rsp_valid = (cnt_q != '0);
  assign rsp_data  = mem_q[rd_ptr_q].data;
  assign rsp_id    = mem_q[rd_ptr_q].id;
  assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_mips32_shift_arb.sv
// Scoreboard bench for mips32_shift_arb: a behavioural model predicts grants,
// FIFO occupancy, stall count and shift results; a monitor checks responses.
module tb_mips32_shift_arb;
  import mips32_shift_arb_pkg::*;

  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_data = '0;
  logic [1:0][4:0]  req_amt = '0;
  logic [1:0][1:0]  req_op = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [7:0]       busy_cnt;

  mips32_shift_arb #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  int   m_cnt  = 0;
  bit   m_ptr  = 1'b0;
  int   m_busy = 0;

  logic [1:0][31:0] s_data;
  logic [1:0][4:0]  s_amt;
  logic [1:0][1:0]  s_op;
  bit               force_exp = 1'b0;
  logic [31:0]      forced_val;

  // Bit-by-bit definition of each shift op.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                            input logic [1:0] op);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) begin
      case (op)
        2'b00:   r[k] = (k >= amt) ? d[k-amt] : 1'b0;
        2'b01:   r[k] = (k + amt < 32) ? d[k+amt] : 1'b0;
        2'b10:   r[k] = (k + amt < 32) ? d[k+amt] : d[31];
        default: r[k] = d[(k+amt)%32];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stage_rand();
    for (int i = 0; i < 2; i++) begin
      s_data[i] = $urandom;
      s_amt[i]  = 5'($urandom_range(0, 31));
      s_op[i]   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic rr);
    bit         pop_p;
    bit         space;
    int         g;
    logic [1:0] rdy_e;
    exp_t       e;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    req_data  = s_data;
    req_amt   = s_amt;
    req_op    = s_op;
    #1;
    pop_p = (m_cnt != 0) && rr;
    space = (m_cnt < DEPTH) || pop_p;
    g     = (v == 2'b11) ? int'(m_ptr) : ((v == 2'b10) ? 1 : 0);
    rdy_e = '0;
    if (v != 2'b00 && space) rdy_e[g] = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_cnt != 0));
    check("req_ready", 32'(req_ready), 32'(rdy_e));
    check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
    if (rdy_e != 2'b00) begin
      e.id   = g[0];
      e.data = force_exp ? forced_val : ref_shift(s_data[g], int'(s_amt[g]), s_op[g]);
      sb.push_back(e);
      m_ptr = (g == 0);
    end else if (v != 2'b00 && m_busy < 255) begin
      m_busy++;
    end
    m_cnt = m_cnt + ((rdy_e != 2'b00) ? 1 : 0) - (pop_p ? 1 : 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rsp: got data 0x%08h id %0d with empty scoreboard", rsp_data, rsp_id);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
    end
  end

  logic [31:0] ops_exp [5];
  logic [1:0]  ops_op  [5];
  logic [4:0]  ops_amt [5];

  initial begin : driver
    ops_exp = '{32'h23456780, 32'h01234567, 32'h01234567, 32'h81234567, 32'h12345678};
    ops_op  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    ops_amt = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
    stage_rand();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: grants alternate starting at requester 0.
    for (int i = 0; i < 4; i++) begin
      stage_rand();
      cycle(2'b11, 1'b1);
    end
    cycle(2'b00, 1'b1);

    // Single SRA with sign fill.
    s_data[0] = 32'h80000001; s_amt[0] = 5'd1; s_op[0] = 2'b10;
    force_exp = 1'b1; forced_val = 32'hC0000000;
    cycle(2'b01, 1'b1);
    force_exp = 1'b0;
    cycle(2'b00, 1'b1);

    // Fixed operand through every op, plus zero amount.
    for (int i = 0; i < 5; i++) begin
      s_data[1] = 32'h12345678; s_amt[1] = ops_amt[i]; s_op[1] = ops_op[i];
      force_exp = 1'b1; forced_val = ops_exp[i];
      cycle(2'b10, 1'b1);
    end
    force_exp = 1'b0;
    cycle(2'b00, 1'b1);

    // Backpressure: two accepts fill the FIFO, then stalls count up.
    for (int i = 0; i < 5; i++) begin
      stage_rand();
      cycle(2'b10, 1'b0);
    end
    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 3; i++) begin
      stage_rand();
      cycle(2'b01, 1'b1);
    end
    repeat (3) cycle(2'b00, 1'b1);

    // Reset with two queued results.
    stage_rand();
    cycle(2'b11, 1'b0);
    cycle(2'b11, 1'b0);
    cycle(2'b01, 1'b0);
    @(negedge clk);
    req_valid = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    sb.delete();
    m_cnt = 0; m_ptr = 1'b0; m_busy = 0;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (3) cycle(2'b00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      stage_rand();
      cycle(2'b11, 1'b1);
    end

    // Long stall to saturate the stall counter.
    repeat (262) cycle(2'b01, 1'b0);
    repeat (3) cycle(2'b00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      stage_rand();
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    // Bounded drain.
    for (int i = 0; i < 20 && (sb.size() != 0 || m_cnt != 0); i++) cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b1);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips32_shift_arb.md
MIPS32_SHIFT_ARB -- requirements
Module: mips32_shift_arb

Interface
REQ-001 Parameter DEPTH, default 2, output FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; transfer when valid&ready high on a clk edge.
REQ-006 req_data  input  2x32  operand per requester.
REQ-007 req_amt  input  2x5  shift amount per requester.
REQ-008 req_op  input  2x2  op per requester: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
REQ-009 rsp_valid  output  1  response FIFO head valid.
REQ-010 rsp_ready  input  1  consumer accept of head.
REQ-011 rsp_data  output  32  shifted result at head.
REQ-012 rsp_id  output  1  requester index owning head.
REQ-013 busy_cnt  output  8  saturating count of cycles any req_valid was high with no grant (stall counter).

Function
REQ-014 At most one req_ready bit SHALL be high per cycle.
REQ-015 Grant: only one valid -> that requester; both valid -> requester named by priority pointer ptr.
REQ-016 ptr SHALL become the non-granted index after every accepted transfer; unchanged otherwise.
REQ-017 req_ready[i] SHALL be high iff i is granted and (FIFO count < DEPTH or rsp_ready & rsp_valid this cycle).
REQ-018 req_ready SHALL depend combinationally only on req_valid, ptr, FIFO count and rsp_ready.
REQ-019 Accepted operand SHALL be shifted combinationally the same cycle and result plus id written to FIFO tail.
REQ-020 SLL/SRL fill zeros; SRA fills with data[31]; ROTR rotates right; amount 0 returns operand unchanged for all ops.
REQ-021 Latency: request accepted in cycle N with FIFO empty SHALL show rsp_valid=1 in cycle N+1.
REQ-022 FIFO SHALL be strictly in-order; head pops when rsp_valid & rsp_ready.
REQ-023 Full FIFO with simultaneous pop and push: both occur, count unchanged, no data loss.
REQ-024 Empty FIFO: rsp_valid=0, rsp_data/rsp_id hold last value (not checked).
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-026 busy_cnt SHALL increment by 1 each cycle with req_valid!=0 and req_ready==0, saturating at 255.
REQ-027 Requester dropping req_valid without a transfer SHALL NOT alter ptr or FIFO.

Reset
REQ-028 rst_n low SHALL asynchronously clear FIFO count and pointers, ptr=0, busy_cnt=0, rsp_valid=0.
REQ-029 req_ready SHALL be 0 while rst_n is low.
REQ-030 Reset mid-operation SHALL discard all queued results; no response emitted after release until a new accept.

Structure
REQ-031 Shared package SHALL hold the op encodings (SLL, SRL, SRA, ROTR) and the DEPTH default.
REQ-032 Datapath SHALL instantiate the existing combinational shifter mips32_shift as the single sub-module; no second shifter.
REQ-033 FIFO storage, count, pointers, ptr and busy_cnt SHALL be the only state.

Verification
REQ-034 Single: req0 data=0x80000001 amt=1 op=10, rsp_ready=1 -> next cycle rsp_data=0xC0000000, rsp_id=0.
REQ-035 Contention: both valid 4 cycles from reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-036 Backpressure: rsp_ready=0, req1 valid -> 2 accepts then req_ready=0; busy_cnt increments each further cycle.
REQ-037 Full push+pop: FIFO full, rsp_ready=1, req0 valid -> accept and pop same cycle, count stays 2, order preserved.
REQ-038 Ops: data=0x12345678 amt=4 -> SLL 0x23456780, SRL 0x01234567, SRA 0x01234567, ROTR 0x81234567; amt=0 -> 0x12345678.
REQ-039 Reset: assert rst_n low with 2 queued results -> rsp_valid=0 immediately, ptr=0, busy_cnt=0; no stale response after release.
